fphub_csv_writer: RTL and testbench
===================================

# fphub_csv_writer

Synthesizable record writer for the FPHUB adder verification flow, the producing end of the operand/result CSV format consumed by the dataset testbench. It accepts one `{X, Y, Z}` triplet per handshake, either from the adder's operand/result taps or from a stimulus generator. It serializes each triplet as one ASCII line `xxx,yyy,zzz\n` onto a byte stream with valid/ready flow control, preceded by a single header line after reset. Typical sinks are a UART, a trace FIFO or a simulation file dumper, which regenerate dataset files directly from hardware.

## Interface
Parameters:
- `M`, 4, mantissa bits
- `E`, 4, exponent bits
- Derived: `W = E+M+1` (field width); `ND = ceil(W/4)` (hex digits per field); `RL = 3*ND+3` (bytes per record)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  triplet present
- `in_ready`  out  1  writer can accept a triplet
- `in_x`  in  W  operand X
- `in_y`  in  W  operand Y
- `in_z`  in  W  result Z
- `out_valid`  out  1  `out_data` holds a valid byte
- `out_ready`  in  1  sink accepts the byte
- `out_data`  out  8  ASCII byte
- `out_last`  out  1  current byte is the line terminator 0x0A
- `rec_count`  out  32  records fully emitted, excluding the header
- `busy`  out  1  state is not IDLE

## Operation
- **FSM states:** HEADER, IDLE, EMIT.
- **HEADER:** entered on reset. Emits `X,Y,Z\n`, i.e. 0x58 0x2C 0x59 0x2C 0x5A 0x0A. Goes to IDLE after the 0x0A byte handshakes.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready`:
  - latch `in_x`, `in_y`, `in_z` into internal registers;
  - clear the byte index;
  - go to EMIT.
- **EMIT byte order:**
  - X digits (ND), 0x2C, Y digits, 0x2C, Z digits, 0x0A;
  - byte index runs 0..RL-1;
  - on the 0x0A handshake: `rec_count` += 1 (wraps modulo 2^32), go to IDLE.
- **Hex digits:**
  - MSB-first; field zero-extended to 4*ND bits, so the top digit carries only the upper W mod 4 bits when W is not a multiple of 4;
  - digits 0-9 map to 0x30-0x39; 10-15 map to lowercase 0x61-0x66.
- **Latching:** input ports are ignored outside the IDLE accept cycle. Operands held after acceptance cannot change the record being emitted.
- **Backpressure:** when `out_valid && !out_ready`, `out_data`, `out_last` and the byte index hold their values.
- **`out_last`:** asserted exactly with the 0x0A of both the header and each record.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0x00, `out_last`=0, `in_ready`=0, `rec_count`=0, `busy`=1;
  - state=HEADER, byte index=0.
- **First header byte:** `out_valid`=1 in the first cycle after `rst_n` is sampled high.
- **Registered outputs:** `out_data`, `out_valid`, `out_last` and `in_ready` are all registered.
- **Latency:** triplet accepted in cycle t gives `out_valid`=1 with the first X digit in cycle t+1.
- **Throughput:** with `out_ready` held at 1, one byte per cycle. `in_ready` rises in the cycle after the 0x0A handshake. Maximum throughput is one record per RL+1 cycles.
- **Handshake rules:**
  - `in_ready` never depends combinationally on `in_valid`;
  - `out_valid` never drops without a handshake, except on reset.
- **Reset mid-record:**
  - the partial record is discarded and `rec_count` is cleared;
  - `out_valid`=0 the cycle after `rst_n` is sampled low;
  - the header is re-emitted after release.
- **Simultaneous events:** `in_valid` asserted during HEADER or EMIT is not accepted and must be held by the source.

## Structure
- **Package `fphub_csv_pkg`:**
  - state enum `csv_state_t`;
  - ASCII constants `ASC_COMMA`=0x2C, `ASC_LF`=0x0A, `ASC_X`/`ASC_Y`/`ASC_Z`;
  - header byte array;
  - functions `nd_of(W)` and `nibble_to_ascii(logic [3:0])`.
- **Sub-module `fphub_hex_ascii`:** combinational nibble-to-ASCII, one instance shared by all fields via a nibble mux driven by the byte index.
- **Top level:** FSM, byte index counter, triplet registers and output register.

## Test plan
All scenarios use M=E=4 (W=9, ND=3, RL=12) unless stated.
1. **Header:** reset, `out_ready`=1 → bytes 58 2C 59 2C 5A 0A; `out_last` on byte 6 only; `in_ready`=1 the next cycle.
2. **Single record:** `in_x`=9'h0A5, `in_y`=9'h1FF, `in_z`=9'h000 → `0a5,1ff,000\n`, i.e. 30 61 35 2C 31 66 66 2C 30 30 30 0A.
   - `rec_count`=1 after the 0x0A byte.
3. **Backpressure:** `out_ready` pattern 1,0,0,1,0,1… during a record → `out_data` stable across every stall; the 12 bytes arrive in order with no loss or duplicates.
4. **Held input:** `in_valid` held high with new operands throughout a record → exactly one accept per record; the next accept is in the cycle after the 0x0A handshake; throughput is 13 cycles per record.
5. **Reset mid-record:** `rst_n`=0 after the 5th record byte → `out_valid`=0 next cycle and `rec_count`=0; after release the header is re-emitted.
6. **Wide parameters:** M=10, E=5 (W=16, ND=4, RL=15); `in_x`=16'hBEEF, `in_y`=16'h0001, `in_z`=16'hBEF0 → `beef,0001,bef0\n`.

Source files
------------

// File: rtl/fphub_csv_pkg.sv
// Shared types, ASCII constants and helpers for the FPHUB CSV record writer.
package fphub_csv_pkg;

   // Writer FSM: header line after reset, wait for a triplet, emit one record.
   typedef enum logic [1:0] {
      ST_HEADER = 2'd0,
      ST_IDLE   = 2'd1,
      ST_EMIT   = 2'd2
   } csv_state_t;

   // Class of a record byte, decoded from the byte index.
   typedef enum logic [1:0] {
      BK_DIGIT = 2'd0,
      BK_COMMA = 2'd1,
      BK_LF    = 2'd2
   } byte_kind_t;

   localparam logic [7:0] ASC_COMMA = 8'h2C;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_X     = 8'h58;
   localparam logic [7:0] ASC_Y     = 8'h59;
   localparam logic [7:0] ASC_Z     = 8'h5A;

   // Header line "X,Y,Z\n".
   localparam int HDR_LEN = 6;
   localparam logic [7:0] HDR_BYTES [HDR_LEN] = '{ASC_X, ASC_COMMA, ASC_Y, ASC_COMMA, ASC_Z, ASC_LF};

   // Hex digits needed to print a w-bit field.
   function automatic int nd_of(input int w);
      return (w + 3) / 4;
   endfunction

   // Lowercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'a'-'f'.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

endpackage

// File: rtl/fphub_hex_ascii.sv
// Combinational nibble-to-ASCII converter shared by all three record fields.
module fphub_hex_ascii
   import fphub_csv_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   assign ascii = nibble_to_ascii(nibble);

endmodule

// File: rtl/fphub_csv_writer.sv
// Serializes {X,Y,Z} triplets as "xxx,yyy,zzz\n" lines onto a valid/ready
// byte stream, preceded by one "X,Y,Z\n" header line after every reset.
module fphub_csv_writer
   import fphub_csv_pkg::*;
#(
   parameter int M = 4,
   parameter int E = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [E+M:0] in_x,
   input  logic [E+M:0] in_y,
   input  logic [E+M:0] in_z,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic [31:0]  rec_count,
   output logic         busy
);

   localparam int W  = E + M + 1;
   localparam int ND = nd_of(W);
   localparam int RL = 3 * ND + 3;
   localparam int PW = 4 * ND;
   localparam int IW = $clog2(RL);

   // Byte-index landmarks inside one record line.
   localparam logic [IW-1:0] X_LAST   = IW'(ND - 1);
   localparam logic [IW-1:0] X_COMMA  = IW'(ND);
   localparam logic [IW-1:0] Y_LAST   = IW'(2 * ND);
   localparam logic [IW-1:0] Y_COMMA  = IW'(2 * ND + 1);
   localparam logic [IW-1:0] Z_LAST   = IW'(3 * ND + 1);
   localparam logic [IW-1:0] LF_IDX   = IW'(RL - 1);
   localparam logic [IW-1:0] HDR_LAST = IW'(HDR_LEN - 1);

   csv_state_t    state, next_state;
   logic [IW-1:0] idx, nxt_idx;
   logic [W-1:0]  x_q, y_q, z_q;
   logic          hs;

   logic [7:0]    nxt_out_data;
   logic          nxt_out_valid, nxt_out_last;
   logic          load_trip, rec_inc;

   // Record byte generator signals.
   logic [IW-1:0] rec_sel;
   logic [W-1:0]  src_x, src_y, src_z, fld;
   logic [PW-1:0] fpad;
   logic [IW-1:0] pos;
   byte_kind_t    kind;
   logic [3:0]    nibble;
   logic [7:0]    digit_ascii, rec_byte;

   // Header byte generator signals.
   logic [2:0]    hdr_sel;
   logic [7:0]    hdr_byte;

   assign hs   = out_valid && out_ready;
   assign busy = (state != ST_IDLE);

   // In IDLE the first X digit comes straight from the ports so it can be
   // registered in the accept cycle; afterwards the latched triplet is used.
   always_comb begin
      if (state == ST_IDLE) begin
         rec_sel = '0;
         src_x   = in_x;
         src_y   = in_y;
         src_z   = in_z;
      end else begin
         rec_sel = idx + IW'(1);
         src_x   = x_q;
         src_y   = y_q;
         src_z   = z_q;
      end
   end

   // Decode the record byte index into field, digit position and byte class.
   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      kind = BK_LF;
      fld  = src_x;
      pos  = '0;
      if (rec_sel <= X_LAST) begin
         kind = BK_DIGIT;
         fld  = src_x;
         pos  = X_LAST - rec_sel;
      end else if (rec_sel == X_COMMA) begin
         kind = BK_COMMA;
      end else if (rec_sel <= Y_LAST) begin
         kind = BK_DIGIT;
         fld  = src_y;
         pos  = Y_LAST - rec_sel;
      end else if (rec_sel == Y_COMMA) begin
         kind = BK_COMMA;
      end else if (rec_sel <= Z_LAST) begin
         kind = BK_DIGIT;
         fld  = src_z;
         pos  = Z_LAST - rec_sel;
      end
   end

   // pos counts digits from the least-significant end of the zero-extended field.
   assign fpad   = PW'(fld);
   assign nibble = fpad[{pos, 2'b00} +: 4];

   fphub_hex_ascii u_hex (
      .nibble (nibble),
      .ascii  (digit_ascii)
   );

   assign rec_byte = (kind == BK_DIGIT) ? digit_ascii :
                     (kind == BK_COMMA) ? ASC_COMMA : ASC_LF;

   // Header: first byte is loaded while out_valid is low, later ones on handshake.
   assign hdr_sel  = out_valid ? (idx[2:0] + 3'd1) : idx[2:0];
   assign hdr_byte = HDR_BYTES[hdr_sel];

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_HEADER;
      else        state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_HEADER: if (hs && idx == HDR_LAST) next_state = ST_IDLE;
         ST_IDLE:   if (in_valid && in_ready)  next_state = ST_EMIT;
         ST_EMIT:   if (hs && idx == LF_IDX)   next_state = ST_IDLE;
         default:   next_state = ST_HEADER;
      endcase
   end

   // Output logic: next values of the registered byte stream and byte index.
   always_comb begin
      nxt_out_valid = out_valid;
      nxt_out_data  = out_data;
      nxt_out_last  = out_last;
      nxt_idx       = idx;
      load_trip     = 1'b0;
      rec_inc       = 1'b0;
      case (state)
         ST_HEADER: begin
            if (!out_valid) begin
               nxt_out_valid = 1'b1;
               nxt_out_data  = hdr_byte;
               nxt_out_last  = (hdr_sel == 3'(HDR_LEN - 1));
            end else if (hs) begin
               if (idx == HDR_LAST) begin
                  nxt_out_valid = 1'b0;
                  nxt_out_last  = 1'b0;
                  nxt_idx       = '0;
               end else begin
                  nxt_out_data  = hdr_byte;
                  nxt_out_last  = (hdr_sel == 3'(HDR_LEN - 1));
                  nxt_idx       = idx + IW'(1);
               end
            end
         end
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               nxt_out_valid = 1'b1;
               nxt_out_data  = rec_byte;
               nxt_out_last  = 1'b0;
               nxt_idx       = '0;
               load_trip     = 1'b1;
            end
         end
         ST_EMIT: begin
            if (hs) begin
               if (idx == LF_IDX) begin
                  nxt_out_valid = 1'b0;
                  nxt_out_last  = 1'b0;
                  nxt_idx       = '0;
                  rec_inc       = 1'b1;
               end else begin
                  nxt_out_data  = rec_byte;
                  nxt_out_last  = (rec_sel == LF_IDX);
                  nxt_idx       = idx + IW'(1);
               end
            end
         end
         default: begin
            nxt_out_valid = 1'b0;
            nxt_idx       = '0;
         end
      endcase
   end

   // Output register, byte index, input-ready flag and record counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_last  <= 1'b0;
         in_ready  <= 1'b0;
         idx       <= '0;
         rec_count <= '0;
      end else begin
         out_valid <= nxt_out_valid;
         out_data  <= nxt_out_data;
         out_last  <= nxt_out_last;
         in_ready  <= (next_state == ST_IDLE);
         idx       <= nxt_idx;
         if (rec_inc) rec_count <= rec_count + 32'd1;
      end
   end

   // Triplet capture on accept.
   // NOTE: pure data registers are not reset; they are always written before being read.
   always_ff @(posedge clk) begin
      if (load_trip) begin
         x_q <= in_x;
         y_q <= in_y;
         z_q <= in_z;
      end
   end

endmodule

// File: tb/tb_fphub_csv_writer.sv
// Self-checking bench for fphub_csv_writer: header, directed and random
// records, backpressure, held input, mid-record reset and wide parameters.
module tb_fphub_csv_writer;

   localparam int ND = 3;
   localparam int RL = 3 * ND + 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [8:0]  in_x, in_y, in_z;
   logic        out_valid, out_ready, out_last, busy;
   logic [7:0]  out_data;
   logic [31:0] rec_count;

   logic        in_valid_w, in_ready_w;
   logic [15:0] in_x_w, in_y_w, in_z_w;
   logic        out_valid_w, out_ready_w, out_last_w, busy_w;
   logic [7:0]  out_data_w;
   logic [31:0] rec_count_w;

   always #5 clk = ~clk;

   fphub_csv_writer #(.M(4), .E(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .rec_count(rec_count), .busy(busy)
   );

   fphub_csv_writer #(.M(10), .E(5)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_w), .in_ready(in_ready_w),
      .in_x(in_x_w), .in_y(in_y_w), .in_z(in_z_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w),
      .out_data(out_data_w), .out_last(out_last_w),
      .rec_count(rec_count_w), .busy(busy_w)
   );

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int exp_recs = 0;

   logic [7:0] got[$];
   logic       got_last[$];
   logic [7:0] exp_q[$];
   logic       exp_last[$];
   int         acc_cyc[$];
   logic [7:0] got_w[$];
   logic       got_last_w[$];

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: one CSV line as lowercase MSB-first hex digits per field.
   function automatic void model_rec(input int nd, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      logic [31:0] f[3];
      int n;
      f[0] = x; f[1] = y; f[2] = z;
      for (int k = 0; k < 3; k++) begin
         for (int d = nd - 1; d >= 0; d--) begin
            n = int'((f[k] >> (4 * d)) & 32'hF);
            exp_q.push_back(8'(n < 10 ? 48 + n : 87 + n));
            exp_last.push_back(1'b0);
         end
         exp_q.push_back(k < 2 ? 8'h2C : 8'h0A);
         exp_last.push_back(k == 2);
      end
   endfunction

   // One cycle of the narrow DUT: record handshakes, accepts and stall stability.
   task automatic tick();
      if (!rst_n) prev_stall = 1'b0;
      if (prev_stall) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'(prev_data));
         check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (rst_n && out_valid && out_ready) begin
         got.push_back(out_data);
         got_last.push_back(out_last);
      end
      if (rst_n && in_valid && in_ready) begin
         acc_cyc.push_back(cyc);
         model_rec(ND, 32'(in_x), 32'(in_y), 32'(in_z));
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_q();
      got.delete(); got_last.delete(); exp_q.delete(); exp_last.delete(); acc_cyc.delete();
   endtask

   task automatic check_header(input string tag);
      string hdr;
      hdr = "X,Y,Z\n";
      for (int i = 0; i < 20 && got.size() < 6; i++) tick();
      check({tag, "_len"}, 32'(got.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(hdr[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == 5));
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid_low"}, 32'(out_valid), 32'd0);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      string s2, s6;
      int pat[6];
      bit acc_w;
      pat = '{1, 0, 0, 1, 0, 1};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_x = '0; in_y = '0; in_z = '0;
      in_valid_w = 1'b0; out_ready_w = 1'b1;
      in_x_w = '0; in_y_w = '0; in_z_w = '0;
      repeat (3) @(negedge clk);

      // Reset values.
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_rec_count", rec_count, 32'd0);
      check("rst_busy", 32'(busy), 32'd1);

      // Header: first byte in the first cycle after release.
      rst_n = 1'b1;
      tick();
      check("hdr_first_valid", 32'(out_valid), 32'd1);
      check("hdr_first_data", 32'(out_data), 32'h58);
      got.delete(); got_last.delete();
      check_header("hdr");

      // Directed single record, first digit one cycle after accept.
      clear_q();
      s2 = "0a5,1ff,000\n";
      in_x = 9'h0A5; in_y = 9'h1FF; in_z = 9'h000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rec1_latency_valid", 32'(out_valid), 32'd1);
      check("rec1_latency_data", 32'(out_data), 32'h30);
      for (int i = 0; i < 40 && got.size() < RL; i++) tick();
      check("rec1_len", 32'(got.size()), 32'(RL));
      for (int i = 0; i < RL; i++) check($sformatf("rec1_b%0d", i), 32'(got[i]), 32'(s2[i]));
      check("rec1_last_lf", 32'(got_last[RL-1]), 32'd1);
      check("rec1_last_mid", 32'(got_last[3]), 32'd0);
      exp_recs++;
      check("rec1_count", rec_count, 32'(exp_recs));
      check("rec1_in_ready", 32'(in_ready), 32'd1);

      // Backpressure with changing operands after accept.
      clear_q();
      in_x = 9'($urandom()); in_y = 9'($urandom()); in_z = 9'($urandom()); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 200 && got.size() < RL; i++) begin
         out_ready = (i < 6) ? pat[i] != 0 : 1'($urandom());
         in_x = 9'($urandom()); in_y = 9'($urandom()); in_z = 9'($urandom());
         tick();
      end
      out_ready = 1'b1;
      check_stream("bp");
      exp_recs++;
      check("bp_count", rec_count, 32'(exp_recs));

      // Held in_valid with new operands every cycle: one accept per 13 cycles.
      clear_q();
      for (int i = 0; i < 100 && got.size() < 3 * RL; i++) begin
         in_valid = (acc_cyc.size() < 3);
         in_x = 9'($urandom()); in_y = 9'($urandom()); in_z = 9'($urandom());
         tick();
      end
      in_valid = 1'b0;
      check("held_accepts", 32'(acc_cyc.size()), 32'd3);
      check("held_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(RL + 1));
      check("held_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(RL + 1));
      check_stream("held");
      exp_recs += 3;
      check("held_count", rec_count, 32'(exp_recs));

      // Reset after the 5th record byte, then header again.
      clear_q();
      in_x = 9'($urandom()); in_y = 9'($urandom()); in_z = 9'($urandom()); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && got.size() < 5; i++) tick();
      check("mid_bytes", 32'(got.size()), 32'd5);
      rst_n = 1'b0;
      tick();
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_rec_count", rec_count, 32'd0);
      check("mid_in_ready", 32'(in_ready), 32'd0);
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b1;
      got.delete(); got_last.delete();
      tick();
      check("hdr2_first_data", 32'(out_data), 32'h58);
      check_header("hdr2");

      // Wide parameters: W=16, ND=4, RL=15.
      s6 = "beef,0001,bef0\n";
      in_x_w = 16'hBEEF; in_y_w = 16'h0001; in_z_w = 16'hBEF0; in_valid_w = 1'b1;
      acc_w = 1'b0;
      for (int i = 0; i < 80 && got_w.size() < 15; i++) begin
         if (acc_w && out_valid_w) begin
            got_w.push_back(out_data_w);
            got_last_w.push_back(out_last_w);
         end
         if (in_valid_w && in_ready_w) acc_w = 1'b1;
         @(negedge clk);
         if (acc_w) in_valid_w = 1'b0;
      end
      check("wide_len", 32'(got_w.size()), 32'd15);
      for (int i = 0; i < 15; i++) begin
         check($sformatf("wide_b%0d", i), 32'(got_w[i]), 32'(s6[i]));
         check($sformatf("wide_last%0d", i), 32'(got_last_w[i]), 32'(i == 14));
      end
      @(negedge clk);
      check("wide_count", rec_count_w, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
